// File: rtl/i2c_pkg.sv
// Shared types and constants for the SCCB request arbiter: FSM states,
// default device address and request-word width.
package i2c_pkg;

    localparam logic [7:0] DEV_ADDR_DEF = 8'h78;
    localparam int         REQ_W        = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_CHECK,
        ST_GAP,
        ST_DONE
    } state_t;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Request/engine bundle between the two requesting ports, the arbiter and the
// I2C engine. The arbiter side uses master; the environment uses slave.
interface i2c_req_arbiter_if;
    import i2c_pkg::*;

    logic             cfg_done;
    logic             req0;
    logic             req1;
    logic [REQ_W-1:0] req0_data;
    logic [REQ_W-1:0] req1_data;
    logic             req0_done;
    logic             req1_done;
    logic             req0_err;
    logic             req1_err;
    logic [31:0]      i2c_data;
    logic             i2c_start;
    logic             i2c_tr_end;
    logic             i2c_ack_err;
    logic             busy;
    logic             owner;

    modport master (
        input  cfg_done, req0, req1, req0_data, req1_data, i2c_tr_end, i2c_ack_err,
        output req0_done, req1_done, req0_err, req1_err, i2c_data, i2c_start, busy, owner
    );

    modport slave (
        output cfg_done, req0, req1, req0_data, req1_data, i2c_tr_end, i2c_ack_err,
        input  req0_done, req1_done, req0_err, req1_err, i2c_data, i2c_start, busy, owner
    );

endinterface

// File: rtl/i2c_req_arbiter.sv
// Two-port arbiter in front of an SCCB/I2C write engine: grants one request at a
// time, retries NACKed writes, aborts hung attempts and reports done/err per port.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = DEV_ADDR_DEF,
    parameter int         TIMEOUT_CYC = 2000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic               clock_i2c,
    input  logic               camera_rstn,
    i2c_req_arbiter_if.master  bus
);

    localparam int              RW        = cnt_width(MAX_RETRY + 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic [31:0]     data_reg,  data_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [15:0]     tmo_reg,   tmo_next;
    logic            ack_reg,   ack_next;
    logic            err_reg,   err_next;

    logic            elig0;
    logic            elig1;
    logic            pick;

    // Port 1 only competes once the init sequence has finished.
    assign elig0 = bus.req0;
    assign elig1 = bus.req1 & bus.cfg_done;
    assign pick  = (elig0 && elig1) ? ~owner_reg : elig1;

    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            data_reg  <= 32'd0;
            retry_reg <= '0;
            tmo_reg   <= 16'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            data_reg  <= data_next;
            retry_reg <= retry_next;
            tmo_reg   <= tmo_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        data_next  = data_reg;
        retry_next = retry_reg;
        tmo_next   = tmo_reg;
        ack_next   = ack_reg;
        err_next   = err_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    owner_next = pick;
                    data_next  = {DEV_ADDR, (pick ? bus.req1_data : bus.req0_data)};
                    retry_next = '0;
                    tmo_next   = 16'd0;
                    ack_next   = 1'b0;
                    err_next   = 1'b0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                if (bus.i2c_tr_end) begin
                    ack_next   = bus.i2c_ack_err;
                    state_next = ST_CHECK;
                end else if (tmo_reg >= TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else if (tmo_reg != 16'hFFFF) begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            ST_CHECK: begin
                if (ack_reg && (retry_reg < RETRY_MAX)) begin
                    retry_next = retry_reg + 1'b1;
                    state_next = ST_GAP;
                end else begin
                    err_next   = ack_reg;
                    state_next = ST_DONE;
                end
            end
            // The engine keeps tr_end up until start drops; wait it out before resending.
            ST_GAP: begin
                if (!bus.i2c_tr_end) begin
                    tmo_next   = 16'd0;
                    state_next = ST_XFER;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.i2c_start = (state_reg == ST_XFER);
        bus.busy      = (state_reg == ST_LOAD) || (state_reg == ST_XFER) ||
                        (state_reg == ST_CHECK) || (state_reg == ST_GAP);
        bus.req0_done = (state_reg == ST_DONE) && !owner_reg;
        bus.req1_done = (state_reg == ST_DONE) &&  owner_reg;
        bus.req0_err  = (state_reg == ST_DONE) && !owner_reg && err_reg;
        bus.req1_err  = (state_reg == ST_DONE) &&  owner_reg && err_reg;
        bus.i2c_data  = data_reg;
        bus.owner     = owner_reg;
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a small engine model that ACKs,
// NACKs or hangs depending on eng_mode.
module tb_i2c_req_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    i2c_req_arbiter_if bus();

    i2c_req_arbiter dut (
        .clock_i2c   (clk),
        .camera_rstn (rstn),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // engine model: 0 = ACK, 1 = NACK, 2 = never ends
    int   eng_mode  = 0;
    int   dly       = 0;
    logic start_prev = 1'b0;
    int   start_cnt = 0;
    int   hi_cnt    = 0;
    int   done_cnt  = 0;
    int   dbl_cnt   = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.i2c_start && !start_prev) start_cnt++;
        if (bus.i2c_start) hi_cnt++;
        start_prev = bus.i2c_start;
        if (!bus.i2c_start) begin
            bus.i2c_tr_end  = 1'b0;
            bus.i2c_ack_err = 1'b0;
            dly = 0;
        end else if (!bus.i2c_tr_end && eng_mode != 2) begin
            if (dly == 2) begin
                bus.i2c_tr_end  = 1'b1;
                bus.i2c_ack_err = (eng_mode == 1);
            end else begin
                dly++;
            end
        end
        if (bus.req0_done || bus.req1_done) done_cnt++;
        if ((bus.req0_done || bus.req1_done) && done_prev) dbl_cnt++;
        done_prev = bus.req0_done || bus.req1_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (bus.req0_done || bus.req1_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.cfg_done = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.req0_data = 24'd0;
        bus.req1_data = 24'd0;
        repeat (3) tick();
        tests_run++; if (bus.i2c_start !== 1'b0) begin tests_failed++; $display("FAIL reset_start got=%0b exp=0", bus.i2c_start); end
        tests_run++; if (bus.i2c_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", bus.i2c_data); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        tests_run++; if (bus.owner !== 1'b0) begin tests_failed++; $display("FAIL reset_owner got=%0b exp=0", bus.owner); end
        tests_run++; if ({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_done_err got=%b exp=0000", {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err});
        end
        rstn = 1'b1;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_single();
        bit ok;
        int s;
        s = start_cnt;
        bus.req0_data = 24'h3b0083;
        bus.req0 = 1'b1;
        tick();
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got=%0b exp=1", bus.busy); end
        tests_run++; if (bus.i2c_data !== 32'h783b0083) begin tests_failed++; $display("FAIL single_data got=%h exp=783b0083", bus.i2c_data); end
        bus.req0 = 1'b0;
        wait_done(50, ok);
        tests_run++; if (!ok || bus.req0_done !== 1'b1 || bus.req1_done !== 1'b0) begin
            tests_failed++; $display("FAIL single_done got=%0b%0b exp=10", bus.req0_done, bus.req1_done);
        end
        tests_run++; if (bus.req0_err !== 1'b0) begin tests_failed++; $display("FAIL single_err got=%0b exp=0", bus.req0_err); end
        tests_run++; if (start_cnt - s != 1) begin tests_failed++; $display("FAIL single_starts got=%0d exp=1", start_cnt - s); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_done got=%0b exp=0", bus.busy); end
        tick();
        tests_run++; if (bus.req0_done !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width got=%0b exp=0", bus.req0_done); end
        $display("[TB] single req0 data=%h", bus.i2c_data);
    endtask

    task automatic test_gate();
        bit ok;
        int s;
        s = start_cnt;
        bus.cfg_done = 1'b0;
        bus.req1_data = 24'h1a2b3c;
        bus.req1 = 1'b1;
        repeat (20) tick();
        tests_run++; if (bus.busy !== 1'b0 || start_cnt != s) begin
            tests_failed++; $display("FAIL gate_blocked busy=%0b starts=%0d exp busy=0 starts=0", bus.busy, start_cnt - s);
        end
        bus.cfg_done = 1'b1;
        tick();
        tests_run++; if (bus.busy !== 1'b1 || bus.owner !== 1'b1) begin
            tests_failed++; $display("FAIL gate_grant busy=%0b owner=%0b exp 1/1", bus.busy, bus.owner);
        end
        bus.req1 = 1'b0;
        wait_done(50, ok);
        tests_run++; if (!ok || bus.req1_done !== 1'b1 || bus.req1_err !== 1'b0) begin
            tests_failed++; $display("FAIL gate_done done=%0b err=%0b exp 1/0", bus.req1_done, bus.req1_err);
        end
        tests_run++; if (bus.i2c_data !== 32'h781a2b3c) begin tests_failed++; $display("FAIL gate_data got=%h exp=781a2b3c", bus.i2c_data); end
        $display("[TB] gated req1 data=%h", bus.i2c_data);
    endtask

    task automatic test_round_robin();
        bit ok;
        logic exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_data [2] = '{32'h78111111, 32'h78222222};
        logic got;
        bus.cfg_done = 1'b1;
        bus.req0_data = 24'h111111;
        bus.req1_data = 24'h222222;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(50, ok);
            got = bus.req1_done;
            tests_run++; if (!ok || got !== exp_port[k] || bus.owner !== exp_port[k]) begin
                tests_failed++; $display("FAIL rr_grant%0d got=%0b exp=%0b", k, got, exp_port[k]);
            end
            tests_run++; if (bus.i2c_data !== exp_data[exp_port[k]]) begin
                tests_failed++; $display("FAIL rr_data%0d got=%h exp=%h", k, bus.i2c_data, exp_data[exp_port[k]]);
            end
            $display("[TB] rr transfer %0d port=%0b data=%h", k, got, bus.i2c_data);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_nack();
        bit ok;
        int s;
        s = start_cnt;
        eng_mode = 1;
        bus.req0_data = 24'h0a0b0c;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_done(200, ok);
        tests_run++; if (!ok || bus.req0_done !== 1'b1 || bus.req0_err !== 1'b1) begin
            tests_failed++; $display("FAIL nack_done done=%0b err=%0b exp 1/1", bus.req0_done, bus.req0_err);
        end
        tests_run++; if (start_cnt - s != 4) begin tests_failed++; $display("FAIL nack_starts got=%0d exp=4", start_cnt - s); end
        $display("[TB] nack req0 attempts=%0d", start_cnt - s);
        eng_mode = 0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int h;
        int s;
        h = hi_cnt;
        s = start_cnt;
        eng_mode = 2;
        bus.req0_data = 24'h555555;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_done(2100, ok);
        tests_run++; if (!ok || bus.req0_done !== 1'b1 || bus.req0_err !== 1'b1) begin
            tests_failed++; $display("FAIL tmo_done done=%0b err=%0b exp 1/1", bus.req0_done, bus.req0_err);
        end
        tests_run++; if (hi_cnt - h != 2000) begin tests_failed++; $display("FAIL tmo_start_cycles got=%0d exp=2000", hi_cnt - h); end
        tests_run++; if (bus.i2c_start !== 1'b0 || start_cnt - s != 1) begin
            tests_failed++; $display("FAIL tmo_start start=%0b starts=%0d exp 0/1", bus.i2c_start, start_cnt - s);
        end
        $display("[TB] timeout req0 start_cycles=%0d", hi_cnt - h);
        eng_mode = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        eng_mode = 2;
        bus.cfg_done = 1'b1;
        bus.req1_data = 24'h777777;
        bus.req1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        repeat (5) tick();
        tests_run++; if (bus.i2c_start !== 1'b1 || bus.owner !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_pre start=%0b owner=%0b exp 1/1", bus.i2c_start, bus.owner);
        end
        d = done_cnt;
        rstn = 1'b0;
        #1;
        tests_run++; if ({bus.i2c_start, bus.busy, bus.owner, bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err} !== 7'd0 ||
                         bus.i2c_data !== 32'd0) begin
            tests_failed++; $display("FAIL rstmid_outputs start=%0b busy=%0b owner=%0b data=%h exp all 0",
                                     bus.i2c_start, bus.busy, bus.owner, bus.i2c_data);
        end
        tick();
        rstn = 1'b1;
        eng_mode = 0;
        repeat (10) tick();
        tests_run++; if (done_cnt != d || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_no_done dones=%0d busy=%0b exp 0/0", done_cnt - d, bus.busy);
        end
        bus.req0_data = 24'h123456;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_done(50, ok);
        tests_run++; if (!ok || bus.req0_done !== 1'b1 || bus.req0_err !== 1'b0 || bus.i2c_data !== 32'h78123456) begin
            tests_failed++; $display("FAIL rstmid_recover done=%0b err=%0b data=%h exp 1/0/78123456",
                                     bus.req0_done, bus.req0_err, bus.i2c_data);
        end
        $display("[TB] reset mid-transfer then req0 data=%h", bus.i2c_data);
    endtask

    task automatic test_done_width();
        tests_run++; if (dbl_cnt != 0) begin tests_failed++; $display("FAIL done_width multi_cycle_pulses got=%0d exp=0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gate();
        test_round_robin();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_done_width();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter DEV_ADDR, default 8'h78, SCCB write address prepended to every transfer.
REQ-002 Parameter TIMEOUT_CYC, default 2000, clock_i2c cycles allowed per attempt before abort.
REQ-003 Parameter MAX_RETRY, default 3, re-attempts allowed after a NACK.
REQ-004 clock_i2c  input  1  I2C control clock (20 kHz); single clock domain.
REQ-005 camera_rstn  input  1  reset, asynchronous, active-low.
REQ-006 cfg_done  input  1  high once the init register sequence is complete; gates port 1.
REQ-007 req0 / req1  input  1  transfer request from port 0 (init config) / port 1 (runtime control: strobe, exposure).
REQ-008 req0_data / req1_data  input  24  {reg_addr[15:0], reg_val[7:0]}.
REQ-009 req0_done / req1_done  output  1  one-cycle completion pulse to the owning port.
REQ-010 req0_err / req1_err  output  1  valid with done; high = NACK after all retries, or timeout.
REQ-011 i2c_data  output  32  {DEV_ADDR, latched req data} to the I2C engine.
REQ-012 i2c_start  output  1  engine start, held until tr_end.
REQ-013 i2c_tr_end  input  1  engine transfer-end flag.
REQ-014 i2c_ack_err  input  1  engine NACK flag, sampled with tr_end.
REQ-015 busy  output  1  high from grant until the done pulse.
REQ-016 owner  output  1  index of the port currently or last granted.

Function
REQ-017 States: IDLE, LOAD, XFER, CHECK, GAP, DONE.
REQ-018 IDLE: cfg_done=0 -> only req0 eligible; cfg_done=1 -> round-robin; on a tie the port opposite owner wins.
REQ-019 IDLE with an eligible req -> LOAD: latch data into i2c_data, set owner, clear retry and timeout counters, busy=1.
REQ-020 LOAD -> XFER next cycle; XFER drives i2c_start=1.
REQ-021 XFER: tr_end=1 -> i2c_start=0, capture ack_err, -> CHECK.
REQ-022 XFER: timeout counter reaches TIMEOUT_CYC-1 without tr_end -> i2c_start=0, error flag set, -> DONE.
REQ-023 CHECK: ack_err=1 and retry<MAX_RETRY -> retry+1, -> GAP; otherwise -> DONE with err=ack_err.
REQ-024 GAP: wait for tr_end=0, then clear the timeout counter and -> XFER; the same i2c_data word is resent.
REQ-025 DONE: pulse done/err of owner for exactly one cycle, busy=0, -> IDLE.
REQ-026 The request is sampled only in IDLE; req deassertion mid-transfer is ignored and the transfer completes.
REQ-027 A requester holding req after done is re-arbitrated; port 0 cannot starve port 1 once cfg_done=1.
REQ-028 i2c_data is stable from LOAD through DONE.
REQ-029 Total attempts per request = 1+MAX_RETRY maximum; the retry counter width is clog2(MAX_RETRY+1).
REQ-030 Timeout counter width is 16 bits; it saturates and does not wrap.

Reset
REQ-031 Reset puts all of the following to 0 and the state to IDLE: i2c_start, i2c_data, busy, owner, both done, both err, retry, timeout.
REQ-032 Reset mid-transfer aborts immediately; no done pulse is produced.

Structure
REQ-033 A shared package (i2c_pkg) holds the state enumeration, the DEV_ADDR default and the 24-bit request-word width constant.
REQ-034 Single module, no sub-modules; the engine is instantiated alongside it by the parent.

Verification
REQ-035 Scenario: req0 with 24'h3b0083 and an ACKing engine model -> i2c_data=32'h783b0083, one start, req0_done=1 and req0_err=0 in a single cycle.
REQ-036 Scenario: req1 asserted while cfg_done=0 -> no grant; cfg_done rises -> granted, completes.
REQ-037 Scenario: req0 and req1 held with cfg_done=1 -> grants alternate 0,1,0,1 over 4 transfers.
REQ-038 Scenario: engine NACKs every attempt -> exactly 4 starts, then done with err=1.
REQ-039 Scenario: engine never asserts tr_end -> start drops after 2000 cycles, done with err=1.
REQ-040 Scenario: camera_rstn pulsed low during XFER -> all outputs 0, no done pulse, next request is served normally.
